// File: rtl/axi4l_master.sv
// AXI4-Lite initiator: converts one core load/store request into a single AXI4-Lite
// read or write transaction, one outstanding at a time.
module axi4l_master (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_req_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   input  logic [3:0]  mem_wstrb_i,
   output logic        mem_rdy_o,
   output logic        mem_done_o,
   output logic [31:0] mem_rdata_o,
   output logic        mem_err_o,
   output logic [31:0] m_axi_awaddr,
   output logic [2:0]  m_axi_awprot,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic [31:0] m_axi_araddr,
   output logic [2:0]  m_axi_arprot,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready
);

   localparam int MemAddrBus = 32;
   localparam int MemBus     = 32;

   typedef enum logic [2:0] {
      IDLE,
      WADDR,
      WRESP,
      RADDR,
      RDATA,
      DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [MemAddrBus-1:0]   addr_q, addr_d;
   logic [MemBus-1:0]       wdata_q, wdata_d;
   logic [MemBus/8-1:0]     wstrb_q, wstrb_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    arvalid_q, arvalid_d;
   logic [MemBus-1:0]       rdata_q, rdata_d;
   logic                    err_q, err_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (mem_req_i) begin
               addr_d  = mem_addr_i;
               wdata_d = mem_wdata_i;
               wstrb_d = mem_wstrb_i;
               if (mem_we_i) begin
                  state_d   = WADDR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = RADDR;
                  arvalid_d = 1'b1;
               end
            end
         end
         // AW and W retire independently; leave once neither is still pending
         WADDR: begin
            if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
            if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
               state_d = WRESP;
            end
         end
         WRESP: begin
            if (m_axi_bvalid) begin
               err_d   = m_axi_bresp[1];
               state_d = DONE;
            end
         end
         RADDR: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = RDATA;
            end
         end
         RDATA: begin
            if (m_axi_rvalid) begin
               rdata_d = m_axi_rdata;
               err_d   = m_axi_rresp[1];
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_rdy_o     = (state_q == IDLE);
   assign mem_done_o    = (state_q == DONE);
   assign mem_rdata_o   = rdata_q;
   assign mem_err_o     = err_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = (state_q == WRESP);
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = (state_q == RDATA);

endmodule
